axis_arbiter: RTL and testbench
===============================

# axis_arbiter

Packet-level round-robin arbiter that lets several byte-wide AXI-Stream sources share one stream sink, such as the emitter's stream input and UART. Once a source is granted, it owns the output until it sends a beat with tlast, so packets are never interleaved. A beat-count watchdog forces a packet boundary so that a source that never asserts tlast cannot hold the sink indefinitely. One registered output stage decouples the sink's i_tready from the source-side o_tready.

## Interface
- NUM_SRC, default 4: number of sources; legal range 2..16.
- MAXLEN, default 256: maximum beats per grant before tlast is forced; 0 disables the watchdog.
- i_clk  in  1: clock; all state changes on the rising edge.
- i_rst  in  1: reset, asynchronous, active-high.
- i_tdata  in  8*NUM_SRC: source data; source k uses bits [8k+7:8k].
- i_tlast  in  NUM_SRC: per-source end of packet.
- i_tvalid  in  NUM_SRC: per-source valid.
- o_tready  out  NUM_SRC: per-source ready; at most one bit high at any time.
- o_tdata  out  8: registered output data.
- o_tlast  out  1: registered output last; includes forced last.
- o_tvalid  out  1: registered output valid.
- i_tready  in  1: sink ready.
- o_grant  out  clog2(NUM_SRC): index of the current or last granted source.
- o_busy  out  1: high while in LOCKED.

## Operation
- **State machine:** two states, IDLE and LOCKED. Reset state is IDLE with priority pointer ptr = 0.
- **IDLE:**
  - o_tready = 0 for every source.
  - If any i_tvalid is high, select the first valid source scanning ptr, ptr+1, … with modulo-NUM_SRC wrap.
  - At the next edge: o_grant becomes the selected index, beat counter cnt becomes 0, and the state goes to LOCKED.
  - If no source is valid, remain in IDLE.
- **LOCKED:**
  - o_tready[o_grant] = slot_free, where slot_free = !o_tvalid || i_tready. All other o_tready bits are 0.
  - **Accepted beat:** occurs when i_tvalid[o_grant] && o_tready[o_grant].
    - Load o_tdata, set o_tvalid = 1.
    - Set o_tlast = i_tlast[o_grant] || forced, where forced = (MAXLEN != 0) && (cnt == MAXLEN-1).
    - cnt increments.
  - **Packet end:** if an accepted beat has o_tlast set, go to IDLE and set ptr = (o_grant+1) mod NUM_SRC at the same edge.
  - **Mid-packet:** if i_tvalid of the granted source drops, stay LOCKED, wait, and do not re-arbitrate.
- **Output register:** o_tvalid clears when i_tready is high and no new beat is loaded. It holds o_tdata and o_tlast stable while o_tvalid && !i_tready.
- **Counter width:** cnt is clog2(MAXLEN+1) bits. It never wraps because a forced last occurs first.
- **Fairness:** a source that has just finished has the lowest priority in the next arbitration. No source waits more than NUM_SRC-1 packets.
- **Watchdog:** a forced last terminates the grant. The source's remaining beats continue after a later grant, starting a new packet.
- **Reset mid-operation:** asynchronous clear of all state. The partial packet is dropped. Outputs return to their reset values immediately, not on the next edge.

## Timing
- **Reset values:** o_tvalid=0, o_tlast=0, o_tdata=0, o_tready=0, o_grant=0, o_busy=0.
- **Grant latency:** i_tvalid rising in IDLE at cycle 0 gives o_busy=1 and o_tready[k]=1 in cycle 1. The first beat is accepted at the cycle-1 edge, and o_tvalid=1 in cycle 2.
- **Throughput:** one beat per cycle while LOCKED with the sink always ready. Exactly one IDLE bubble cycle between consecutive packets.
- **Simultaneous events:**
  - Output beat consumed and new beat loaded in the same cycle gives no bubble.
  - A tlast beat accepted while other sources are valid gives IDLE for the next cycle, then a grant to the next source after the old o_grant.
- **Backpressure:** sink backpressure propagates combinationally to o_tready within the same cycle. There is no other combinational path from inputs to outputs.

## Test plan
- **Single source:** NUM_SRC=4. Source 2 sends 3 beats 0x11, 0x22, 0x33 with tlast on 0x33, sink always ready.
  - o_grant=2 and o_busy=1 in cycle 1.
  - Output 0x11/0x22/0x33 in cycles 2–4, o_tlast only with 0x33.
  - o_busy=0 in cycle 4, ptr=3.
- **Round robin:** all 4 sources continuously valid, 2-beat packets. Grant order is 0,1,2,3,0, and each packet is contiguous on the output with 1 bubble between packets.
- **Backpressure:** i_tready held low for 5 cycles mid-packet.
  - o_tdata and o_tlast are stable while held.
  - o_tready[grant]=0 while the register is full.
  - No beat is lost or duplicated after release.
- **Watchdog:** MAXLEN=4, source 1 streams 10 beats without tlast, with source 3 also valid.
  - Beat 4 is output with o_tlast=1.
  - Source 3's packet follows, then source 1 resumes from beat 5.
- **Async reset:** assert i_rst mid-packet between clock edges.
  - o_tvalid, o_busy, and o_tready drop immediately.
  - After release, with source 0 valid, arbitration restarts from ptr=0 and o_grant=0.
- **Stall:** the granted source drops i_tvalid for 3 cycles mid-packet while others are valid. o_grant is unchanged, and there are no output beats until the source resumes.

Source files
------------

// File: rtl/axis_arbiter.sv
// Packet-level round-robin arbiter merging byte-wide AXI-Stream sources onto one
// sink, with a beat-count watchdog and a single registered output stage.
module axis_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int MAXLEN  = 256
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [8*NUM_SRC-1:0]       i_tdata,
  input  logic [NUM_SRC-1:0]         i_tlast,
  input  logic [NUM_SRC-1:0]         i_tvalid,
  output logic [NUM_SRC-1:0]         o_tready,
  output logic [7:0]                 o_tdata,
  output logic                       o_tlast,
  output logic                       o_tvalid,
  input  logic                       i_tready,
  output logic [$clog2(NUM_SRC)-1:0] o_grant,
  output logic                       o_busy
);
  localparam int GW = $clog2(NUM_SRC);
  localparam int CW = (MAXLEN > 0) ? $clog2(MAXLEN + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (MAXLEN > 0) ? CW'(MAXLEN - 1) : '0;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state;
  logic [GW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [GW-1:0] sel;
  logic [GW-1:0] cand;
  logic          found;
  logic          slot_free;
  logic          accept;
  logic          forced;
  logic          beat_last;
  int unsigned   idx;
  logic [7:0]    src_data [NUM_SRC];

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign src_data[k] = i_tdata[8*k +: 8];
  end

  // First valid source at or after ptr, wrapping modulo NUM_SRC.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      idx  = (i + 32'(ptr)) % 32'(NUM_SRC);
      cand = GW'(idx);
      if (!found && i_tvalid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    slot_free = !o_tvalid || i_tready;
    o_tready  = '0;
    if (state == LOCKED) begin
      o_tready[o_grant] = slot_free;
    end
    accept    = (state == LOCKED) && i_tvalid[o_grant] && slot_free;
    forced    = (MAXLEN != 0) && (cnt == CNT_LAST);
    beat_last = i_tlast[o_grant] || forced;
  end

  assign o_busy = (state == LOCKED);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      o_grant  <= '0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
      o_tvalid <= 1'b0;
    end else begin
      if (accept) begin
        o_tdata  <= src_data[o_grant];
        o_tlast  <= beat_last;
        o_tvalid <= 1'b1;
      end else if (i_tready) begin
        o_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (found) begin
            o_grant <= sel;
            cnt     <= '0;
            state   <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (beat_last) begin
              state <= IDLE;
              ptr   <= (o_grant == GW'(NUM_SRC - 1)) ? '0 : o_grant + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_arbiter.sv
// Scoreboard bench for axis_arbiter: a packet-level round-robin model predicts
// the output beat stream; a separate monitor pops and compares each output beat.
module tb_axis_arbiter;
  localparam int NS   = 4;
  localparam int ML   = 4;
  localparam int MAXB = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [8*NS-1:0] i_tdata;
  logic [NS-1:0]   i_tlast;
  logic [NS-1:0]   i_tvalid;
  logic [NS-1:0]   o_tready;
  logic [7:0]      o_tdata;
  logic            o_tlast;
  logic            o_tvalid;
  logic            i_tready;
  logic [1:0]      o_grant;
  logic            o_busy;

  axis_arbiter #(.NUM_SRC(NS), .MAXLEN(ML)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_tdata (i_tdata),
    .i_tlast (i_tlast),
    .i_tvalid(i_tvalid),
    .o_tready(o_tready),
    .o_tdata (o_tdata),
    .o_tlast (o_tlast),
    .o_tvalid(o_tvalid),
    .i_tready(i_tready),
    .o_grant (o_grant),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         s;
    bit         first;
  } beat_t;

  beat_t      sbq[$];
  int         checks   = 0;
  int         failures = 0;
  bit         sb_en    = 1'b1;
  bit         strict   = 1'b0;
  int         phase_id = 0;
  int         ptr_m    = 0;
  int         first_src;
  logic [7:0] sd  [NS][MAXB];
  bit         sl  [NS][MAXB];
  bit         sok [NS][MAXB];
  int         sn  [NS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_srcs();
    for (int k = 0; k < NS; k++) sn[k] = 0;
  endtask

  task automatic add_beat(input int k, input logic [7:0] d, input bit l);
    sd[k][sn[k]] = d;
    sl[k][sn[k]] = l;
    sn[k]++;
  endtask

  task automatic add_pkt(input int k, input int len);
    for (int b = 0; b < len; b++) add_beat(k, 8'($urandom), b == len - 1);
  endtask

  // Packet-level reference: each grant takes beats until tlast or ML beats,
  // then the pointer moves past the granted source.
  task automatic model_build();
    int p[NS];
    int s, c, n;
    bit ended, lst;
    foreach (p[k]) p[k] = 0;
    first_src = -1;
    forever begin
      s = -1;
      for (int i = 0; i < NS; i++) begin
        c = (ptr_m + i) % NS;
        if (s < 0 && p[c] < sn[c]) s = c;
      end
      if (s < 0) break;
      if (first_src < 0) first_src = s;
      n = 0;
      ended = 1'b0;
      while (p[s] < sn[s]) begin
        lst = sl[s][p[s]] || (n == ML - 1);
        sok[s][p[s]] = (n != 0);
        sbq.push_back('{sd[s][p[s]], lst, s, n == 0});
        p[s]++;
        n++;
        if (lst) begin
          ended = 1'b1;
          break;
        end
      end
      if (!ended) break;
      ptr_m = (s + 1) % NS;
    end
  endtask

  task automatic run_phase(input int ready_pct, input int stall_pct, input bit strict_in,
                           input int busy_low_cyc);
    int pos[NS];
    int stl[NS];
    bit hs[NS];
    int cyc;
    bit done;
    model_build();
    strict = strict_in;
    phase_id++;
    for (int k = 0; k < NS; k++) begin
      pos[k] = 0;
      stl[k] = 0;
      hs[k]  = 1'b0;
    end
    cyc = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NS; k++) begin
        if (hs[k]) begin
          pos[k]++;
          if (pos[k] < sn[k] && sok[k][pos[k]] && $urandom_range(0, 99) < stall_pct)
            stl[k] = $urandom_range(1, 3);
        end
      end
      done = (sbq.size() == 0);
      for (int k = 0; k < NS; k++) if (pos[k] != sn[k]) done = 1'b0;
      if (done) break;
      if (cyc >= 3000) begin
        chk("phase_done", 32'(done), 32'd1);
        sbq.delete();
        break;
      end
      i_tready = ($urandom_range(0, 99) < ready_pct);
      for (int k = 0; k < NS; k++) begin
        i_tvalid[k]       = (pos[k] < sn[k]) && (stl[k] == 0);
        i_tdata[8*k +: 8] = sd[k][pos[k] % MAXB];
        i_tlast[k]        = sl[k][pos[k] % MAXB];
        if (stl[k] > 0) begin
          chk("stall_grant", 32'(o_grant), 32'(k));
          chk("stall_busy", 32'(o_busy), 32'd1);
          stl[k]--;
        end
      end
      #1;
      chk("tready_onehot", 32'($onehot0(o_tready)), 32'd1);
      if (o_tvalid && !i_tready) chk("tready_full", 32'(o_tready), 32'd0);
      if (cyc == 1) begin
        chk("grant_lat_busy", 32'(o_busy), 32'd1);
        chk("grant_lat_idx", 32'(o_grant), 32'(first_src));
        chk("grant_lat_tready", 32'(o_tready), 32'(1 << first_src));
      end
      if (cyc == 2) chk("first_beat_valid", 32'(o_tvalid), 32'd1);
      if (cyc == busy_low_cyc) chk("busy_drop", 32'(o_busy), 32'd0);
      for (int k = 0; k < NS; k++) hs[k] = i_tvalid[k] && o_tready[k];
      cyc++;
    end
    i_tvalid = '0;
    i_tlast  = '0;
    i_tready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin : monitor
    int         gap        = 0;
    int         last_phase = 0;
    bit         held       = 1'b0;
    logic [7:0] hd         = '0;
    logic       hl         = 1'b0;
    beat_t      e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        chk("hold_valid", 32'(o_tvalid), 32'd1);
        chk("hold_data", 32'(o_tdata), 32'(hd));
        chk("hold_last", 32'(o_tlast), 32'(hl));
      end
      held = o_tvalid && !i_tready;
      hd   = o_tdata;
      hl   = o_tlast;
      if (o_tvalid && i_tready && sb_en) begin
        chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("out_data", 32'(o_tdata), 32'(e.d));
          chk("out_last", 32'(o_tlast), 32'(e.l));
          if (!e.l) chk("out_grant", 32'(o_grant), 32'(e.s));
          if (strict && last_phase == phase_id) chk("gap", 32'(gap), e.first ? 32'd1 : 32'd0);
        end
        last_phase = phase_id;
        gap = 0;
      end else begin
        gap++;
      end
    end
  end

  initial begin
    rst      = 1'b1;
    i_tvalid = '0;
    i_tlast  = '0;
    i_tdata  = '0;
    i_tready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 32'(o_tvalid), 32'd0);
    chk("rst_tlast", 32'(o_tlast), 32'd0);
    chk("rst_tdata", 32'(o_tdata), 32'd0);
    chk("rst_tready", 32'(o_tready), 32'd0);
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    clear_srcs();
    add_beat(2, 8'h11, 1'b0);
    add_beat(2, 8'h22, 1'b0);
    add_beat(2, 8'h33, 1'b1);
    run_phase(100, 0, 1'b1, 4);

    clear_srcs();
    for (int k = 0; k < NS; k++) begin
      add_pkt(k, 2);
      add_pkt(k, 2);
    end
    run_phase(100, 0, 1'b1, -1);

    clear_srcs();
    for (int k = 0; k < NS; k++) for (int p = 0; p < 3; p++) add_pkt(k, $urandom_range(2, 4));
    run_phase(40, 0, 1'b0, -1);

    clear_srcs();
    for (int k = 0; k < NS; k++) for (int p = 0; p < 2; p++) add_pkt(k, $urandom_range(3, 4));
    run_phase(100, 60, 1'b0, -1);

    repeat (4) begin
      clear_srcs();
      for (int k = 0; k < NS; k++) begin
        int np;
        np = $urandom_range(1, 3);
        for (int p = 0; p < np; p++) add_pkt(k, $urandom_range(1, 7));
      end
      run_phase(70, 30, 1'b0, -1);
    end

    clear_srcs();
    for (int b = 0; b < 10; b++) add_beat(1, 8'(8'h41 + b), 1'b0);
    add_pkt(3, 3);
    run_phase(100, 0, 1'b1, -1);

    // Source 1 is still holding the grant with two beats of its last chunk sent.
    sb_en = 1'b0;
    @(negedge clk);
    i_tvalid        = 4'b0010;
    i_tdata[15:8]   = 8'h5A;
    i_tlast         = '0;
    i_tready        = 1'b1;
    @(negedge clk);
    #3;
    chk("pre_rst_busy", 32'(o_busy), 32'd1);
    chk("pre_rst_tvalid", 32'(o_tvalid), 32'd1);
    chk("pre_rst_tready", 32'(o_tready), 32'h2);
    rst = 1'b1;
    #1;
    chk("arst_tvalid", 32'(o_tvalid), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_tready", 32'(o_tready), 32'd0);
    chk("arst_tdata", 32'(o_tdata), 32'd0);
    chk("arst_tlast", 32'(o_tlast), 32'd0);
    chk("arst_grant", 32'(o_grant), 32'd0);
    i_tvalid = '0;
    @(negedge clk);
    rst   = 1'b0;
    ptr_m = 0;
    sb_en = 1'b1;
    repeat (2) @(negedge clk);

    clear_srcs();
    for (int k = 0; k < NS; k++) add_pkt(k, 2);
    run_phase(100, 0, 1'b1, -1);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
